// File: rtl/mem_bus_arbiter.sv
// Two-requester memory port arbiter: load/store has fixed priority over fetch,
// with a saturating starvation counter that forces a waiting fetch through.
module mem_bus_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned AW           = 32
) (
    input  logic          i_CLK,
    input  logic          i_RSTn,
    input  logic          i_I_REQ,
    input  logic [AW-1:0] i_I_ADDR,
    output logic          o_I_GNT,
    output logic [31:0]   o_I_RDATA,
    input  logic          i_D_REQ,
    input  logic          i_D_WE,
    input  logic [3:0]    i_D_BE,
    input  logic [AW-1:0] i_D_ADDR,
    input  logic [31:0]   i_D_WDATA,
    output logic          o_D_GNT,
    output logic [31:0]   o_D_RDATA,
    output logic          o_MEM_REQ,
    output logic          o_MEM_WE,
    output logic [3:0]    o_MEM_BE,
    output logic [AW-1:0] o_MEM_ADDR,
    output logic [31:0]   o_MEM_WDATA,
    input  logic          i_MEM_GNT,
    input  logic [31:0]   i_MEM_RDATA
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOwnI = 2'd1,
        StOwnD = 2'd2
    } state_e;

    localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

    state_e     state_q, state_d;
    logic [3:0] starve_q, starve_d;
    logic       sel_i, sel_d;
    logic       gnt_i, gnt_d;

    // State register
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            state_q  <= StIdle;
            starve_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Mux select: arbitrate in IDLE, otherwise locked to the owner while it keeps requesting.
    // Gated by reset so the bus goes quiet the instant reset asserts.
    always_comb begin
        sel_i = 1'b0;
        sel_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_I_REQ && (!i_D_REQ || starve_q == StarveMax)) begin
                    sel_i = 1'b1;
                end else if (i_D_REQ) begin
                    sel_d = 1'b1;
                end
            end
            StOwnI:  sel_i = i_I_REQ;
            StOwnD:  sel_d = i_D_REQ;
            default: ;
        endcase
        if (!i_RSTn) begin
            sel_i = 1'b0;
            sel_d = 1'b0;
        end
    end

    assign gnt_i = sel_i & i_MEM_GNT;
    assign gnt_d = sel_d & i_MEM_GNT;

    // Next state and starvation counter
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        unique case (state_q)
            StIdle: begin
                if (sel_i && !i_MEM_GNT) begin
                    state_d = StOwnI;
                end else if (sel_d && !i_MEM_GNT) begin
                    state_d = StOwnD;
                end
            end
            StOwnI: begin
                if (!i_I_REQ || i_MEM_GNT) state_d = StIdle;
            end
            StOwnD: begin
                if (!i_D_REQ || i_MEM_GNT) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (gnt_i) begin
            starve_d = 4'd0;
        end else if (gnt_d && i_I_REQ && starve_q < StarveMax) begin
            starve_d = starve_q + 4'd1;
        end
    end

    // Outputs
    always_comb begin
        o_MEM_REQ   = sel_i | sel_d;
        o_MEM_WE    = 1'b0;
        o_MEM_BE    = 4'h0;
        o_MEM_ADDR  = '0;
        o_MEM_WDATA = 32'h0;
        if (sel_i) begin
            o_MEM_BE   = 4'hF;
            o_MEM_ADDR = i_I_ADDR;
        end else if (sel_d) begin
            o_MEM_WE    = i_D_WE;
            o_MEM_BE    = i_D_BE;
            o_MEM_ADDR  = i_D_ADDR;
            o_MEM_WDATA = i_D_WDATA;
        end
        o_I_GNT   = gnt_i;
        o_D_GNT   = gnt_d;
        o_I_RDATA = gnt_i ? i_MEM_RDATA : 32'h0;
        o_D_RDATA = gnt_d ? i_MEM_RDATA : 32'h0;
    end

endmodule
